// File: rtl/mix_columns_engine.sv
// Column-serial AES MixColumns/InvMixColumns engine with valid/ready on both sides.
// Define MIXCOL_INV_EN to build the inverse matrix and honour in_inv; otherwise forward only.

module mix_column_unit (
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);
    logic [3:0][7:0] w_a, w_x2, w_r;
`ifdef MIXCOL_INV_EN
    logic [3:0][7:0] w_x4, w_x8;
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    always_comb begin
        w_a  = '0;
        w_x2 = '0;
        w_r  = '0;
`ifdef MIXCOL_INV_EN
        w_x4 = '0;
        w_x8 = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            w_a[i]  = i_col[31-8*i -: 8];
            w_x2[i] = xt(w_a[i]);
`ifdef MIXCOL_INV_EN
            w_x4[i] = xt(w_x2[i]);
            w_x8[i] = xt(w_x4[i]);
`endif
        end
        for (int i = 0; i < 4; i++) begin
            // forward row: 02 03 01 01 rotated by i
            w_r[i] = w_x2[i] ^ w_x2[(i+1)%4] ^ w_a[(i+1)%4] ^ w_a[(i+2)%4] ^ w_a[(i+3)%4];
`ifdef MIXCOL_INV_EN
            // inverse row: 0e 0b 0d 09 built from x2/x4/x8 terms
            if (i_inv)
                w_r[i] = (w_x8[i] ^ w_x4[i] ^ w_x2[i])
                       ^ (w_x8[(i+1)%4] ^ w_x2[(i+1)%4] ^ w_a[(i+1)%4])
                       ^ (w_x8[(i+2)%4] ^ w_x4[(i+2)%4] ^ w_a[(i+2)%4])
                       ^ (w_x8[(i+3)%4] ^ w_a[(i+3)%4]);
`endif
        end
        o_col = {w_r[0], w_r[1], w_r[2], w_r[3]};
    end
endmodule

module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam int NCYC = 4 / COLS_PER_CYCLE;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                              r_state, w_state_nxt;
    logic [CW-1:0]                       r_cnt;
    logic [127:0]                        r_work, w_work_nxt, r_out_data;
    logic                                r_out_valid;
    logic                                w_mode, w_accept, w_last;
    logic [COLS_PER_CYCLE-1:0][1:0]      w_sel;
    logic [COLS_PER_CYCLE-1:0][31:0]     w_col_in, w_col_out;

`ifdef MIXCOL_INV_EN
    logic r_inv;
    assign w_mode = r_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_mode       = 1'b0;
`endif

    assign in_ready  = ~rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == CW'(NCYC - 1));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        assign w_sel[l]    = 2'((32'(r_cnt) * COLS_PER_CYCLE) + l);
        assign w_col_in[l] = r_work[127 - 32*w_sel[l] -: 32];
        mix_column_unit u_mix (
            .i_col (w_col_in[l]),
            .i_inv (w_mode),
            .o_col (w_col_out[l])
        );
    end

    // Results land in place so the working register becomes the finished state.
    always_comb begin
        w_work_nxt = r_work;
        for (int c = 0; c < 4; c++)
            if ((c / COLS_PER_CYCLE) == 32'(r_cnt))
                w_work_nxt[127-32*c -: 32] = w_col_out[c % COLS_PER_CYCLE];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY: if (w_last)   w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = w_accept ? S_BUSY : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
`ifdef MIXCOL_INV_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_work <= in_data;
                r_cnt  <= '0;
`ifdef MIXCOL_INV_EN
                r_inv  <= in_inv;
`endif
            end else if (r_state == S_BUSY) begin
                r_work <= w_work_nxt;
                r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) r_out_data <= w_work_nxt;
            end
            if ((r_state == S_BUSY) && w_last)
                r_out_valid <= 1'b1;
            else if ((r_state == S_DONE) && out_ready)
                r_out_valid <= 1'b0;
        end
    end
endmodule
